qdiv_seq: RTL and testbench

- Sequential sign-magnitude fixed-point divider; the inverse operation of the codec's combinational fixed-point multiplier, in the same (N,Q) number format.
- Computes quotient = dividend / divisor using a restoring shift-subtract algorithm that produces one quotient bit per clock.
- Used by the LPC/pitch and energy normalisation stages, where a multi-cycle latency is acceptable in exchange for small area.
- A start/done handshake lets a controlling FSM issue divisions and collect results.

---
 rtl/qdiv_seq.sv | 140 ++++++++++++++
 tb/tb_qdiv_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/qdiv_seq.sv
// Restoring sign-magnitude (N,Q) divider, one quotient bit per clock; QDIV_ROUND_EN adds a guard bit and rounds half-up.
// Latency: o_done K+1 edges after accept (K+2 rounded, 1 on divide-by-zero); i_start is ignored while busy.
module qdiv_seq #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_ovr,
  output logic         o_div0
);

  localparam int K = N - 1 + Q;
`ifdef QDIV_ROUND_EN
  localparam int ITER = K + 1;
`else
  localparam int ITER = K;
`endif
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    rem_q;
  logic [ITER-1:0] num_q;
  logic [ITER-1:0] quo_q;
  logic [N-2:0]    bmag_q;
  logic            sign_q;
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            last_it;
  logic            b_zero;
  logic [N-1:0]    rem_sh;
  logic [N-1:0]    rem_nxt;
  logic            q_bit;
  logic [ITER-1:0] mag_full;
  logic            sat;
  logic [N-2:0]    mag;
  logic            res_sign;

  assign b_zero  = (bmag_q == '0);
  assign last_it = (cnt_q == CW'(ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        o_busy = 1'b1;
        if (b_zero)       state_nxt = DONE;
        else if (last_it) state_nxt = FIN;
      end
      FIN: state_nxt = DONE;
      DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The remainder stays below |b| < 2^(N-1), so the bit shifted out is always zero.
  always_comb begin
    rem_sh  = (rem_q << 1) | N'(num_q[ITER-1]);
    q_bit   = (rem_sh >= {1'b0, bmag_q});
    rem_nxt = q_bit ? (rem_sh - {1'b0, bmag_q}) : rem_sh;
  end

`ifdef QDIV_ROUND_EN
  assign mag_full = {1'b0, quo_q[ITER-1:1]} + ITER'(quo_q[0]);
`else
  assign mag_full = quo_q;
`endif

  assign sat      = |mag_full[ITER-1:N-1];
  assign mag      = sat ? {(N-1){1'b1}} : mag_full[N-2:0];
  assign res_sign = sign_q & (mag != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_quotient <= '0;
      o_ovr      <= 1'b0;
      o_div0     <= 1'b0;
      rem_q      <= '0;
      num_q      <= '0;
      quo_q      <= '0;
      bmag_q     <= '0;
      sign_q     <= 1'b0;
      cnt_q      <= '0;
    end else if (accept) begin
      sign_q <= i_dividend[N-1] ^ i_divisor[N-1];
      bmag_q <= i_divisor[N-2:0];
      num_q  <= {i_dividend[N-2:0], {(ITER-N+1){1'b0}}};
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      o_ovr  <= 1'b0;
      o_div0 <= 1'b0;
    end else if (state == RUN) begin
      if (b_zero) begin
        o_div0     <= 1'b1;
        o_quotient <= {sign_q, {(N-1){1'b1}}};
      end else begin
        rem_q <= rem_nxt;
        num_q <= num_q << 1;
        quo_q <= {quo_q[ITER-2:0], q_bit};
        cnt_q <= cnt_q + CW'(1);
      end
    end else if (state == FIN) begin
      o_quotient <= {res_sign, mag};
      o_ovr      <= sat;
    end
  end

endmodule

// File: tb/tb_qdiv_seq.sv
// Bench for qdiv_seq: directed vector table, hand-written control sequences, random operands vs arithmetic model.
module tb_qdiv_seq;

  localparam int Q = 15;
  localparam int N = 32;
  localparam int K = N - 1 + Q;
`ifdef QDIV_ROUND_EN
  localparam int ITER = K + 1;
  localparam logic [31:0] THIRD_Q = 32'h00002AAB;
`else
  localparam int ITER = K;
  localparam logic [31:0] THIRD_Q = 32'h00002AAA;
`endif
  localparam int LAT = ITER + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_dividend = '0;
  logic [31:0] i_divisor = '0;
  logic [31:0] o_quotient;
  logic        o_busy, o_done, o_ovr, o_div0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        ovr;
    logic        div0;
    int          lat;
    int          busy;
  } vec_t;

  vec_t tbl[$];

  qdiv_seq #(.Q(Q), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_quotient (o_quotient),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_ovr      (o_ovr),
    .o_div0     (o_div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic ovr, input logic div0);
    vec_t v;
    v.nm = nm; v.a = a; v.b = b; v.q = q; v.ovr = ovr; v.div0 = div0;
    v.lat  = div0 ? 1 : LAT;
    v.busy = div0 ? 1 : ITER;
    tbl.push_back(v);
  endtask

  // Plain-arithmetic reference: scale, integer divide, round, saturate.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic ovr, output logic div0);
    longint unsigned am, bm, raw;
    logic s;
    am = 64'(a[30:0]);
    bm = 64'(b[30:0]);
    s  = a[31] ^ b[31];
    ovr = 1'b0;
    div0 = 1'b0;
    if (bm == 0) begin
      div0 = 1'b1;
      q = {s, 31'h7FFFFFFF};
      return;
    end
`ifdef QDIV_ROUND_EN
    raw = (am << (Q + 1)) / bm;
    raw = (raw >> 1) + (raw & 64'd1);
`else
    raw = (am << Q) / bm;
`endif
    if (raw > 64'h7FFFFFFF) begin
      ovr = 1'b1;
      raw = 64'h7FFFFFFF;
    end
    q = {(raw != 0) ? s : 1'b0, raw[30:0]};
  endfunction

  // Issue one division; optionally pulse i_start again pulse_at edges after accept.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int pulse_at,
                        output int lat, output int busy);
    bit got;
    @(negedge clk);
    i_start = 1'b1; i_dividend = a; i_divisor = b;
    @(posedge clk); #1;
    i_start = 1'b0; i_dividend = $urandom; i_divisor = $urandom;
    lat = 0; busy = 0; got = 0;
    while (lat < 200 && !got) begin
      if (o_busy) busy++;
      if (lat == pulse_at) begin
        i_start = 1'b1; i_dividend = 32'h00010000; i_divisor = 32'h00030000;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      got = o_done;
    end
    i_start = 1'b0;
  endtask

  initial begin
    int lat, busy, n, dn;
    bit got;
    logic [31:0] a, b, eq;
    logic eo, ed;

    add("basic",    32'h00018000, 32'h00010000, 32'h0000C000, 1'b0, 1'b0);
    add("sign_neg", 32'h00008000, 32'h80020000, 32'h80002000, 1'b0, 1'b0);
    add("neg_neg",  32'h80008000, 32'h80008000, 32'h00008000, 1'b0, 1'b0);
    add("third",    32'h00008000, 32'h00018000, THIRD_Q,      1'b0, 1'b0);
    add("ovf",      32'h40000000, 32'h00004000, 32'h7FFFFFFF, 1'b1, 1'b0);
    add("zero_res", 32'h00000000, 32'h80008000, 32'h00000000, 1'b0, 1'b0);
    add("max_by1",  32'h7FFFFFFF, 32'h00008000, 32'h7FFFFFFF, 1'b0, 1'b0);
    add("tiny_lsb", 32'h80000001, 32'h00000001, 32'h80008000, 1'b0, 1'b0);
    add("div0",     32'h80008000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1);
    add("div0_nz",  32'h00008000, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", o_quotient, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ovr", o_ovr, 0);
    chk("rst_div0", o_div0, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      do_div(tbl[i].a, tbl[i].b, -1, lat, busy);
      chk({tbl[i].nm, "_q"},    o_quotient, tbl[i].q);
      chk({tbl[i].nm, "_ovr"},  o_ovr,      tbl[i].ovr);
      chk({tbl[i].nm, "_div0"}, o_div0,     tbl[i].div0);
      chk({tbl[i].nm, "_lat"},  lat,        tbl[i].lat);
      chk({tbl[i].nm, "_busy"}, busy,       tbl[i].busy);
    end

    // A start pulse in the middle of RUN must not disturb the running division.
    do_div(32'h00018000, 32'h00010000, 10, lat, busy);
    chk("runpulse_q", o_quotient, 32'h0000C000);
    chk("runpulse_lat", lat, LAT);

    // Start held high through DONE: second division starts with no IDLE cycle.
    @(negedge clk);
    i_start = 1'b1; i_dividend = 32'h00018000; i_divisor = 32'h00010000;
    @(posedge clk); #1;
    i_dividend = 32'h00008000; i_divisor = 32'h80020000;
    n = 0; got = 0;
    while (n < 200 && !got) begin
      @(posedge clk); #1;
      n++;
      got = o_done;
    end
    chk("b2b_lat1", n, LAT);
    chk("b2b_q1", o_quotient, 32'h0000C000);
    @(posedge clk); #1;
    chk("b2b_busy", o_busy, 1);
    chk("b2b_nodone", o_done, 0);
    i_start = 1'b0;
    n = 0; got = 0;
    while (n < 200 && !got) begin
      @(posedge clk); #1;
      n++;
      got = o_done;
    end
    chk("b2b_lat2", n, LAT);
    chk("b2b_q2", o_quotient, 32'h80002000);

    // Reset during iteration 20 aborts the division.
    @(negedge clk);
    i_start = 1'b1; i_dividend = 32'h00018000; i_divisor = 32'h00010000;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_q", o_quotient, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_ovr", o_ovr, 0);
    chk("abort_div0", o_div0, 0);
    rst = 1'b0;
    dn = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (o_done) dn++;
    end
    chk("abort_no_done", dn, 0);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = {1'($urandom), 15'd0, 16'($urandom)};
        2: b = {1'($urandom), 31'd0};
        default: b = {1'($urandom), 31'($urandom_range(1, 1 << 22))};
      endcase
      if ($urandom_range(0, 3) == 0) a = {a[31], 15'd0, a[15:0]};
      model(a, b, eq, eo, ed);
      do_div(a, b, -1, lat, busy);
      chk("rand_q",    o_quotient, eq);
      chk("rand_ovr",  o_ovr,      eo);
      chk("rand_div0", o_div0,     ed);
      chk("rand_lat",  lat,        ed ? 1 : LAT);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
